// File: rtl/ixu_wb_arbiter_if.sv
// Writeback-lane, register-file write port and pending-write lookup bundle
// for ixu_wb_arbiter.
interface ixu_wb_arbiter_if #(
   parameter int unsigned N_LANES = 2
);
   logic [N_LANES-1:0]    lane_wr_en;
   logic [5*N_LANES-1:0]  lane_rd;
   logic [32*N_LANES-1:0] lane_data;
   logic                  stall;
   logic                  rf_wr_en;
   logic [4:0]            rf_rd;
   logic [31:0]           rf_data;
   logic [4:0]            query_rs;
   logic                  query_hit;
   logic [31:0]           query_data;

   modport master (
      output lane_wr_en, lane_rd, lane_data, query_rs,
      input  stall, rf_wr_en, rf_rd, rf_data, query_hit, query_data
   );

   modport slave (
      input  lane_wr_en, lane_rd, lane_data, query_rs,
      output stall, rf_wr_en, rf_rd, rf_data, query_hit, query_data
   );
endinterface

// File: rtl/ixu_wb_arbiter.sv
// Shares one register-file write port among N_LANES writeback lanes through an
// in-order FIFO drained one write per cycle, with a pending-write lookup.
module ixu_wb_arbiter #(
   parameter int unsigned N_LANES = 2,
   parameter int unsigned DEPTH   = 4
) (
   input logic            clk,
   input logic            rst,
   ixu_wb_arbiter_if.slave bus
);
   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - N_LANES);
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

   logic [4:0]    r_rd   [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_rf_wr_en;
   logic [4:0]    r_rf_rd;
   logic [31:0]   r_rf_data;

   logic             w_stall;
   logic             w_deq;
   logic [CW-1:0]    w_n_enq;
   logic [PW-1:0]    w_tail_next;
   logic [DEPTH-1:0] w_slot_we;
   logic [4:0]       w_slot_rd   [DEPTH];
   logic [31:0]      w_slot_data [DEPTH];
   logic [PW-1:0]    w_scan;
   logic             w_hit;
   logic [31:0]      w_qdata;

   // Pointer increment with explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign w_stall = (r_count > STALL_TH);
   assign w_deq   = (r_count != '0);

   // Accepted lanes pack into consecutive tail slots, lane 0 oldest; x0 writes are dropped.
   always_comb begin
      w_slot_we   = '0;
      w_n_enq     = '0;
      w_tail_next = r_tail;
      for (int unsigned d = 0; d < DEPTH; d++) begin
         w_slot_rd[d]   = '0;
         w_slot_data[d] = '0;
      end
      for (int unsigned i = 0; i < N_LANES; i++) begin
         if (!w_stall && bus.lane_wr_en[i] && (bus.lane_rd[5*i +: 5] != 5'd0)) begin
            w_slot_we[w_tail_next]   = 1'b1;
            w_slot_rd[w_tail_next]   = bus.lane_rd[5*i +: 5];
            w_slot_data[w_tail_next] = bus.lane_data[32*i +: 32];
            w_n_enq                  = w_n_enq + CW'(1);
            w_tail_next              = f_inc(w_tail_next);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned d = 0; d < DEPTH; d++) begin
         if (w_slot_we[d]) begin
            r_rd[d]   <= w_slot_rd[d];
            r_data[d] <= w_slot_data[d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_rf_wr_en <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_data  <= '0;
      end else begin
         r_tail  <= w_tail_next;
         r_count <= r_count + w_n_enq - CW'(w_deq);
         if (w_deq) begin
            r_rf_wr_en <= 1'b1;
            r_rf_rd    <= r_rd[r_head];
            r_rf_data  <= r_data[r_head];
            r_head     <= f_inc(r_head);
         end else begin
            r_rf_wr_en <= 1'b0;
         end
      end
   end

   // Scan oldest to youngest so the youngest match overrides; rf_* is older than any FIFO entry.
   always_comb begin
      w_hit   = 1'b0;
      w_qdata = '0;
      w_scan  = r_head;
      if (bus.query_rs != 5'd0) begin
         if (r_rf_wr_en && (r_rf_rd == bus.query_rs)) begin
            w_hit   = 1'b1;
            w_qdata = r_rf_data;
         end
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) && (r_rd[w_scan] == bus.query_rs)) begin
               w_hit   = 1'b1;
               w_qdata = r_data[w_scan];
            end
            w_scan = f_inc(w_scan);
         end
      end
   end

   assign bus.stall      = w_stall;
   assign bus.rf_wr_en   = r_rf_wr_en;
   assign bus.rf_rd      = r_rf_rd;
   assign bus.rf_data    = r_rf_data;
   assign bus.query_hit  = w_hit;
   assign bus.query_data = w_qdata;
endmodule

// File: tb/tb_ixu_wb_arbiter.sv
// Directed scoreboard bench for ixu_wb_arbiter: expected writes are queued as
// lanes are driven and popped as the register-file port fires.
module tb_ixu_wb_arbiter;
   localparam int unsigned NL = 2;
   localparam int unsigned DP = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ixu_wb_arbiter_if #(.N_LANES(NL)) bus ();
   ixu_wb_arbiter #(.N_LANES(NL), .DEPTH(DP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wb_t         sb[$];
   int unsigned mcount;
   wb_t         last;
   bit          last_v;
   int          n_tests;
   int          n_fail;
   logic [4:0]  q_rs;
   bit          saw_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int unsigned i, input logic en, input logic [4:0] rd,
                           input logic [31:0] data);
      bus.lane_wr_en[i]       = en;
      bus.lane_rd[5*i +: 5]   = rd;
      bus.lane_data[32*i +: 32] = data;
   endtask

   task automatic clr_lanes();
      bus.lane_wr_en = '0;
      bus.lane_rd    = '0;
      bus.lane_data  = '0;
   endtask

   function automatic bit model_stall();
      return mcount > (DP - NL);
   endfunction

   // One clock: record accepted writes, advance the count model, check outputs.
   task automatic tick();
      int unsigned n_enq;
      logic        exp_wen;
      logic        exp_hit;
      logic [31:0] exp_qd;
      wb_t         e;
      n_enq = 0;
      bus.query_rs = q_rs;
      if (!rst && !model_stall()) begin
         for (int unsigned i = 0; i < NL; i++) begin
            if (bus.lane_wr_en[i] && bus.lane_rd[5*i +: 5] != 5'd0) begin
               e.rd   = bus.lane_rd[5*i +: 5];
               e.data = bus.lane_data[32*i +: 32];
               sb.push_back(e);
               n_enq++;
            end
         end
      end
      exp_wen = !rst && (mcount > 0);
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
         mcount = 0;
      end else begin
         mcount = mcount + n_enq - ((mcount > 0) ? 1 : 0);
      end
      chk("rf_wr_en", {31'd0, bus.rf_wr_en}, {31'd0, exp_wen});
      last_v = 1'b0;
      if (bus.rf_wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_rf_write", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rf_rd", {27'd0, bus.rf_rd}, {27'd0, e.rd});
            chk("rf_data", bus.rf_data, e.data);
            last   = e;
            last_v = 1'b1;
         end
      end
      chk("stall", {31'd0, bus.stall}, {31'd0, model_stall()});
      if (model_stall()) saw_stall = 1'b1;
      exp_hit = 1'b0;
      exp_qd  = '0;
      if (q_rs != 5'd0) begin
         for (int k = sb.size() - 1; k >= 0; k--) begin
            if (!exp_hit && sb[k].rd == q_rs) begin
               exp_hit = 1'b1;
               exp_qd  = sb[k].data;
            end
         end
         if (!exp_hit && last_v && last.rd == q_rs) begin
            exp_hit = 1'b1;
            exp_qd  = last.data;
         end
      end
      chk("query_hit", {31'd0, bus.query_hit}, {31'd0, exp_hit});
      chk("query_data", bus.query_data, exp_qd);
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned n;
      n = 0;
      clr_lanes();
      while ((mcount > 0 || sb.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_budget", {31'd0, (mcount > 0 || sb.size() > 0)}, 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dv;
      n_tests   = 0;
      n_fail    = 0;
      mcount    = 0;
      last_v    = 1'b0;
      saw_stall = 1'b0;
      q_rs      = 5'd0;
      rst       = 1'b1;
      clr_lanes();
      bus.query_rs = '0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("reset_rf_rd", {27'd0, bus.rf_rd}, 32'd0);
      chk("reset_rf_data", bus.rf_data, 32'd0);

      // Single write, two-edge latency
      q_rs = 5'd3;
      set_lane(0, 1'b1, 5'd3, 32'hA5);
      tick();
      clr_lanes();
      tick();
      tick();
      tick();

      // Same rd on both lanes; lane 1 is youngest
      q_rs = 5'd5;
      set_lane(0, 1'b1, 5'd5, 32'h11);
      set_lane(1, 1'b1, 5'd5, 32'h22);
      tick();
      clr_lanes();
      tick();
      tick();
      tick();

      // Both lanes every cycle: stall engages, upstream holds while stalled
      q_rs = 5'd7;
      dv   = 32'h100;
      for (int c = 0; c < 10; c++) begin
         if (!model_stall()) begin
            set_lane(0, 1'b1, 5'd7, dv);
            set_lane(1, 1'b1, 5'd8, dv + 32'd1);
            dv = dv + 32'd2;
         end
         tick();
      end
      chk("stall_seen", {31'd0, saw_stall}, 32'd1);
      drain(20);

      // Writes to x0 are dropped
      q_rs = 5'd0;
      set_lane(0, 1'b1, 5'd0, 32'hDEAD);
      set_lane(1, 1'b1, 5'd0, 32'hBEEF);
      tick();
      tick();
      clr_lanes();
      tick();
      tick();

      // Reset with three buffered entries
      q_rs = 5'd9;
      set_lane(0, 1'b1, 5'd9, 32'h901);
      set_lane(1, 1'b1, 5'd10, 32'hA02);
      tick();
      set_lane(0, 1'b1, 5'd9, 32'h903);
      set_lane(1, 1'b1, 5'd11, 32'hB04);
      tick();
      chk("pre_reset_count", mcount, 32'd3);
      clr_lanes();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_reset_rf_rd", {27'd0, bus.rf_rd}, 32'd0);
      tick();
      tick();
      tick();

      // Mixed traffic long enough to wrap the pointers several times
      for (int c = 0; c < 30; c++) begin
         if (!model_stall()) begin
            for (int unsigned i = 0; i < NL; i++)
               set_lane(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom);
         end
         q_rs = 5'($urandom_range(0, 4));
         tick();
      end
      drain(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
